// File: rtl/jtgng_vdly_pkg.sv
// Shared helpers for the variable delay line: clog2 and the width derivations
// that both the interface and the datapath need to agree on.
package jtgng_vdly_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Width of the delay-select port: must encode 0..DEPTH.
  function automatic int vdly_dw(input int depth);
    return clog2(depth + 1);
  endfunction

  // Address width of the DEPTH-1 entry history buffer (at least one bit).
  function automatic int vdly_aw(input int depth);
    return (depth > 2) ? clog2(depth - 1) : 1;
  endfunction

endpackage

// File: rtl/jtgng_vdly_if.sv
// Sample-stream bundle of the variable delay line: advance enable, data,
// delay select and flush in; delayed data and ready out.
interface jtgng_vdly_if
  import jtgng_vdly_pkg::*;
#(
  parameter int W     = 5,
  parameter int DEPTH = 24
);
  localparam int DW = vdly_dw(DEPTH);

  logic          clk_en;
  logic [W-1:0]  din;
  logic [DW-1:0] dly;
  logic          flush;
  logic [W-1:0]  dout;
  logic          ready;

  modport master (output clk_en, din, dly, flush, input dout, ready);
  modport slave  (input clk_en, din, dly, flush, output dout, ready);
endinterface

// File: rtl/jtgng_vdly_mem.sv
// History storage: one write port and one registered write-first read port,
// shaped for block-RAM inference. Contents are never reset.
module jtgng_vdly_mem #(
  parameter int W  = 5,
  parameter int N  = 23,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  q
);
  logic [W-1:0] mem [N];

  // Write-first: a read of the address being written returns the new sample.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    q <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/jtgng_vdly.sv
// Variable delay line: delays din by 1..DEPTH enabled ticks, masking dout to
// zero until the history buffer holds enough samples for the selected delay.
module jtgng_vdly
  import jtgng_vdly_pkg::*;
#(
  parameter int W     = 5,
  parameter int DEPTH = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  jtgng_vdly_if.slave bus
);
  localparam int DW = vdly_dw(DEPTH);
  localparam int AW = vdly_aw(DEPTH);
  localparam int N  = DEPTH - 1;
  localparam int SW = DW + 1;

  localparam logic [DW-1:0] DONE = DW'(1);
  localparam logic [DW-1:0] DMAX = DW'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic [SW-1:0] NS   = SW'(N);

  logic [DW-1:0] d_eff, d_prev;
  logic [DW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] wr, wr_nxt, raddr;
  logic [SW-1:0] rsum;
  logic [W-1:0]  q, dout_r, dout_nxt;
  logic          ready_r, ready_nxt;
  logic          tick, restart;

  always_comb begin
    d_eff = bus.dly;
    if (bus.dly == '0)       d_eff = DONE;
    else if (bus.dly > DMAX) d_eff = DMAX;

    tick    = bus.clk_en && !bus.flush;
    restart = bus.flush || (d_eff != d_prev);

    wr_nxt = wr;
    if (tick) wr_nxt = (wr == LAST) ? '0 : wr + 1'b1;

    // Prefetch the sample the next tick will present: D-1 entries behind the
    // post-edge write pointer, so the read register is ready one tick ahead.
    rsum = SW'(wr_nxt) + NS - SW'(d_eff - 1'b1);
    if (rsum >= NS) rsum = rsum - NS;
    raddr = rsum[AW-1:0];
  end

  always_comb begin
    cnt_nxt   = cnt;
    ready_nxt = ready_r;
    dout_nxt  = dout_r;
    if (restart) begin
      cnt_nxt   = '0;
      ready_nxt = 1'b0;
      dout_nxt  = '0;
    end else if (tick) begin
      cnt_nxt   = (cnt >= d_eff) ? d_eff : cnt + 1'b1;
      ready_nxt = (cnt_nxt == d_eff);
      // D=1 bypasses the buffer: a single register stage on din.
      if (!ready_nxt)          dout_nxt = '0;
      else if (d_eff == DONE)  dout_nxt = bus.din;
      else                     dout_nxt = q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr      <= '0;
      cnt     <= '0;
      d_prev  <= DONE;
      ready_r <= 1'b0;
      dout_r  <= '0;
    end else begin
      wr      <= wr_nxt;
      cnt     <= cnt_nxt;
      d_prev  <= d_eff;
      ready_r <= ready_nxt;
      dout_r  <= dout_nxt;
    end
  end

  jtgng_vdly_mem #(
    .W  (W),
    .N  (N),
    .AW (AW)
  ) u_mem (
    .clk   (clk),
    .we    (tick),
    .waddr (wr),
    .wdata (bus.din),
    .raddr (raddr),
    .q     (q)
  );

  assign bus.dout  = dout_r;
  assign bus.ready = ready_r;

endmodule

// File: tb/tb_jtgng_vdly.sv
// Directed bench for jtgng_vdly: vector table plus hand-written multi-cycle
// sequences for delay changes, flush, buffer wrap and asynchronous reset.
module tb_jtgng_vdly;
  localparam int W     = 5;
  localparam int DEPTH = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtgng_vdly_if #(.W(W), .DEPTH(DEPTH)) bus ();

  jtgng_vdly #(.W(W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       ce;
    logic [4:0] din;
    logic [4:0] dly;
    logic       fl;
    logic [4:0] dout;
    logic       rdy;
  } vec_t;

  vec_t       tq[$];
  int         total  = 0;
  int         passed = 0;
  logic [4:0] hist [1:100];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_out(input string name, input logic [4:0] d, input logic r);
    check({name, " dout"}, 8'(bus.dout), 8'(d));
    check({name, " ready"}, 8'(bus.ready), 8'(r));
  endtask

  task automatic step(input logic ce, input logic [4:0] d, input logic [4:0] dl, input logic fl);
    bus.clk_en = ce;
    bus.din    = d;
    bus.dly    = dl;
    bus.flush  = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic ce, input logic [4:0] d, input logic [4:0] dl, input logic fl,
                     input logic [4:0] eo, input logic er);
    vec_t v;
    v.ce = ce; v.din = d; v.dly = dl; v.fl = fl; v.dout = eo; v.rdy = er;
    tq.push_back(v);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    bus.clk_en = 1'b0;
    bus.din    = '0;
    bus.dly    = 5'd24;
    bus.flush  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 5'd0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    step(0, 5'd0, 5'd24, 0);
    step(0, 5'd0, 5'd24, 0);
    expect_out("idle", 5'd0, 1'b0);

    // Baseline: D=24, counting din
    for (int k = 1; k <= 60; k++) begin
      step(1, 5'(k), 5'd24, 0);
      expect_out($sformatf("base%0d", k), (k >= 24) ? 5'(k - 23) : 5'd0, k >= 24);
    end

    // Enable gating, dly=4, tick every third clock
    add(0, 5'h00, 4, 0, 5'h00, 0);
    add(1, 5'h0A, 4, 0, 5'h00, 0);
    add(0, 5'h1F, 4, 0, 5'h00, 0);
    add(0, 5'h1F, 4, 0, 5'h00, 0);
    add(1, 5'h0B, 4, 0, 5'h00, 0);
    add(0, 5'h1F, 4, 0, 5'h00, 0);
    add(0, 5'h1F, 4, 0, 5'h00, 0);
    add(1, 5'h0C, 4, 0, 5'h00, 0);
    add(0, 5'h1F, 4, 0, 5'h00, 0);
    add(0, 5'h1F, 4, 0, 5'h00, 0);
    add(1, 5'h0D, 4, 0, 5'h0A, 1);
    add(0, 5'h1F, 4, 0, 5'h0A, 1);
    add(0, 5'h1F, 4, 0, 5'h0A, 1);
    add(1, 5'h0E, 4, 0, 5'h0B, 1);
    add(0, 5'h05, 4, 0, 5'h0B, 1);
    // Clamp dly=0 to D=1; dly=1 is the same D so ready stays up
    add(0, 5'h00, 0, 0, 5'h00, 0);
    add(1, 5'h03, 0, 0, 5'h03, 1);
    add(1, 5'h07, 0, 0, 5'h07, 1);
    add(0, 5'h1F, 0, 0, 5'h07, 1);
    add(1, 5'h11, 0, 0, 5'h11, 1);
    add(1, 5'h09, 1, 0, 5'h09, 1);
    // Flush with clk_en low still clears
    add(0, 5'h1F, 1, 1, 5'h00, 0);
    add(1, 5'h04, 1, 0, 5'h04, 1);
    for (int i = 0; i < tq.size(); i++) begin
      step(tq[i].ce, tq[i].din, tq[i].dly, tq[i].fl);
      expect_out($sformatf("vec%0d", i), tq[i].dout, tq[i].rdy);
    end

    // Clamp dly=31 to D=24; switching to dly=24 is not a change
    step(0, 5'd0, 5'd31, 0);
    expect_out("clamp31 chg", 5'd0, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      step(1, 5'(k + 3), 5'd31, 0);
      if (k == 23) expect_out("clamp31 t23", 5'd0, 1'b0);
    end
    expect_out("clamp31 t24", 5'd4, 1'b1);
    step(1, 5'd28, 5'd24, 0);
    expect_out("same D", 5'd5, 1'b1);

    // Runtime change 8 -> 3
    step(0, 5'd0, 5'd8, 0);
    for (int k = 1; k <= 12; k++) step(1, 5'(k), 5'd8, 0);
    expect_out("dly8 steady", 5'd5, 1'b1);
    step(1, 5'd13, 5'd3, 0);
    expect_out("dly3 chg", 5'd0, 1'b0);
    step(1, 5'd14, 5'd3, 0);
    expect_out("dly3 t1", 5'd0, 1'b0);
    step(1, 5'd15, 5'd3, 0);
    expect_out("dly3 t2", 5'd0, 1'b0);
    step(1, 5'd16, 5'd3, 0);
    expect_out("dly3 t3", 5'd14, 1'b1);
    step(1, 5'd17, 5'd3, 0);
    expect_out("dly3 t4", 5'd15, 1'b1);

    // Flush during an enabled tick at dly=6
    step(0, 5'd0, 5'd6, 0);
    for (int k = 1; k <= 10; k++) step(1, 5'(k), 5'd6, 0);
    expect_out("dly6 steady", 5'd5, 1'b1);
    step(1, 5'h1E, 5'd6, 1);
    expect_out("flush", 5'd0, 1'b0);
    for (int k = 11; k <= 17; k++) begin
      step(1, 5'(k), 5'd6, 0);
      expect_out($sformatf("postflush%0d", k), (k >= 16) ? 5'(k - 5) : 5'd0, k >= 16);
    end

    // Wrap: 100 random ticks at D=24 against a linear history
    step(0, 5'd0, 5'd24, 0);
    for (int k = 1; k <= 100; k++) begin
      hist[k] = 5'($urandom);
      step(1, hist[k], 5'd24, 0);
      expect_out($sformatf("wrap%0d", k), (k >= 24) ? hist[k - 23] : 5'd0, k >= 24);
    end

    // Asynchronous reset pulse between edges
    #2 rst_n = 1'b0;
    #1 expect_out("rst async", 5'd0, 1'b0);
    #1 rst_n = 1'b1;
    step(0, 5'd0, 5'd24, 0);
    for (int k = 1; k <= 30; k++) begin
      step(1, 5'(k), 5'd24, 0);
      if (k == 23 || k == 24 || k == 30)
        expect_out($sformatf("refill%0d", k), (k >= 24) ? 5'(k - 23) : 5'd0, k >= 24);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
